spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_if.sv | 23 ++
 rtl/spi_master_ctrl.sv | 110 +++++++++++
 tb/tb_spi_master_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host and SPI-side signal bundle for spi_master_ctrl.
// The master modport is the controller's view and the slave modport is the host/slave side.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic [9:0] cmd_din;
    logic       cmd_ready;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_din, miso,
        output cmd_ready, mosi, ss_n, rd_data, rd_valid, busy
    );

    modport slave (
        output cmd_valid, cmd_din, miso,
        input  cmd_ready, mosi, ss_n, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI frame controller: serialises a 10-bit command word MSB first and, for
// read-data words, waits a turnaround and then collects one byte from miso.
module spi_master_ctrl #(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    spi_master_ctrl_if.master  bus
);

    typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, RECV, GAP} state_t;

    localparam logic [3:0] TURN_LAST = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [9:0] din;
    logic [6:0] shreg;

    always_ff @(posedge clk) begin
        bus.rd_valid <= 1'b0;
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            din           <= '0;
            shreg         <= '0;
            bus.ss_n      <= 1'b1;
            bus.mosi      <= 1'b1;
            bus.rd_data   <= '0;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        din           <= bus.cmd_din;
                        state         <= START;
                        cnt           <= '0;
                        bus.ss_n      <= 1'b0;
                        bus.mosi      <= bus.cmd_din[9];
                        bus.busy      <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                    end
                end
                START: begin
                    state    <= SHIFT;
                    cnt      <= '0;
                    bus.mosi <= din[9];
                end
                SHIFT: begin
                    // cnt is the index of the cycle now on the wire; the next cycle carries din[9-cnt]
                    if (cnt == 4'd10) begin
                        cnt      <= '0;
                        bus.mosi <= 1'b1;
                        if (din[9:8] == 2'b11) begin
                            state <= TURN;
                        end else begin
                            state    <= GAP;
                            bus.ss_n <= 1'b1;
                        end
                    end else begin
                        cnt      <= cnt + 4'd1;
                        bus.mosi <= din[4'd9 - cnt];
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        state <= RECV;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECV: begin
                    shreg <= {shreg[5:0], bus.miso};
                    if (cnt == 4'd7) begin
                        bus.rd_data  <= {shreg, bus.miso};
                        bus.rd_valid <= 1'b1;
                        bus.ss_n     <= 1'b1;
                        state        <= GAP;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    bus.ss_n      <= 1'b1;
                    bus.mosi      <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: write/read frames, back-to-back words,
// mid-frame reset and commands offered while busy.
module tb_spi_master_ctrl;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned GAP_CY = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.RD_LATENCY(RD_LAT), .GAP_CYCLES(GAP_CY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] slave_byte;
    int lowcnt = 0;

    // Slave model: counts ss_n-low cycles and presents slave_byte MSB first during RECV
    always @(negedge clk) begin
        if (bus.ss_n) begin
            lowcnt   = 0;
            bus.miso = 1'b0;
        end else begin
            if (lowcnt >= int'(12 + RD_LAT) && lowcnt < int'(20 + RD_LAT))
                bus.miso = slave_byte[7 - (lowcnt - int'(12 + RD_LAT))];
            else
                bus.miso = 1'b0;
            lowcnt++;
        end
    end

    task automatic capture(input logic [9:0] w, input int pulse_at,
                           output int low, output logic [31:0] bits,
                           output int bsy, output int gap, output int rv);
        int guard;
        bit done;
        low = 0; bits = '0; bsy = 0; gap = 0; rv = 0; guard = 0; done = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_din   = w;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_din   = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1;
                break;
            end
            bsy++;
            if (!bus.ss_n) begin
                low++;
                bits = {bits[30:0], bus.mosi};
            end else begin
                gap++;
            end
            if (bus.rd_valid) rv++;
            if (i == pulse_at) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_din   = 10'h3FF;
            end else if (i == pulse_at + 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_din   = '0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL capture_timeout: busy still %0b after 100 cycles, required 0", bus.busy);
        end
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %0b required 1", bus.ss_n); end
        checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %0b required 1", bus.mosi); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b required 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h required 00", bus.rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int low, bsy, gap, rv;
        logic [31:0] bits;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_din   = 10'h0AB;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (bus.ss_n !== 1'b0) begin errors++; $display("FAIL midrst_in_frame: ss_n got %0b required 0", bus.ss_n); end
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_din   = 10'h3FF;
        @(negedge clk);
        checks++; if (bus.ss_n !== 1'b1) begin errors++; $display("FAIL midrst_ss_n: got %0b required 1", bus.ss_n); end
        checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL midrst_mosi: got %0b required 1", bus.mosi); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready: got %0b required 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b required 0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %0b required 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data: got %0h required 00", bus.rd_data); end
        rst = 1'b0;
        bus.cmd_din = 10'h0AB;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        checks++; if (bus.ss_n !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrst_accept_first_edge: ss_n=%0b busy=%0b required ss_n=0 busy=1", bus.ss_n, bus.busy);
        end
        wait_idle();
        capture(10'h0AB, -1, low, bits, bsy, gap, rv);
        checks++; if (low !== 12) begin errors++; $display("FAIL midrst_next_low: got %0d required 12", low); end
        checks++; if (bits[11:0] !== 12'h0AB) begin errors++; $display("FAIL midrst_next_mosi: got %03h required 0ab", bits[11:0]); end
    endtask

    task automatic test_write_addr();
        int low, bsy, gap, rv;
        logic [31:0] bits;
        capture(10'h0AB, -1, low, bits, bsy, gap, rv);
        checks++; if (low !== 12) begin errors++; $display("FAIL wa_low: got %0d required 12", low); end
        checks++; if (bits[11:0] !== 12'h0AB) begin errors++; $display("FAIL wa_mosi: got %03h required 0ab", bits[11:0]); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL wa_gap: got %0d required 2", gap); end
        checks++; if (rv !== 0) begin errors++; $display("FAIL wa_rd_valid: got %0d required 0", rv); end
    endtask

    task automatic test_write_data();
        int low, bsy, gap, rv;
        logic [31:0] bits;
        capture(10'h1AA, -1, low, bits, bsy, gap, rv);
        checks++; if (bits[11:0] !== 12'h1AA) begin errors++; $display("FAIL wd_mosi: got %03h required 1aa", bits[11:0]); end
        checks++; if (bsy !== 14) begin errors++; $display("FAIL wd_busy: got %0d required 14", bsy); end
        checks++; if (low !== 12) begin errors++; $display("FAIL wd_low: got %0d required 12", low); end
    endtask

    task automatic test_ignore_busy();
        int low, bsy, gap, rv;
        logic [31:0] bits;
        capture(10'h1AA, 4, low, bits, bsy, gap, rv);
        checks++; if (bits[11:0] !== 12'h1AA) begin errors++; $display("FAIL ign_mosi: got %03h required 1aa", bits[11:0]); end
        checks++; if (bsy !== 14) begin errors++; $display("FAIL ign_busy: got %0d required 14", bsy); end
        checks++; if (low !== 12) begin errors++; $display("FAIL ign_low: got %0d required 12", low); end
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_extra_frame: busy got %0b required 0", bus.busy); end
    endtask

    task automatic test_read_data();
        int low, bsy, gap, rv;
        logic [31:0] bits;
        slave_byte = 8'hA5;
        capture(10'h3C7, -1, low, bits, bsy, gap, rv);
        checks++; if (low !== 22) begin errors++; $display("FAIL rd_low: got %0d required 22", low); end
        checks++; if (bits[21:0] !== 22'h3F1FFF) begin errors++; $display("FAIL rd_mosi: got %06h required 3f1fff", bits[21:0]); end
        checks++; if (rv !== 1) begin errors++; $display("FAIL rd_valid_pulses: got %0d required 1", rv); end
        checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data: got %02h required a5", bus.rd_data); end
        checks++; if (bsy !== 24) begin errors++; $display("FAIL rd_busy: got %0d required 24", bsy); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL rd_gap: got %0d required 2", gap); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] ss_v;
        logic [39:0] mo_v;
        logic [11:0] f1;
        logic [11:0] f2;
        int acc2;
        acc2 = -1; f1 = '0; f2 = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_din   = 10'h2AD;
        @(posedge clk);
        #1;
        bus.cmd_din = 10'h0FF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ss_v[i] = bus.ss_n;
            mo_v[i] = bus.mosi;
            if (bus.cmd_ready && acc2 < 0) begin
                acc2 = i;
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
            end
        end
        for (int j = 0; j < 12; j++) f1 = {f1[10:0], mo_v[j]};
        for (int j = 15; j < 27; j++) f2 = {f2[10:0], mo_v[j]};
        checks++; if (ss_v[11:0] !== 12'h000) begin errors++; $display("FAIL b2b_frame1_low: got %03h required 000", ss_v[11:0]); end
        checks++; if (ss_v[14:12] !== 3'b111) begin errors++; $display("FAIL b2b_high_between: got %03b required 111", ss_v[14:12]); end
        checks++; if (acc2 !== 14) begin errors++; $display("FAIL b2b_ready_cycle: got %0d required 14", acc2); end
        checks++; if (ss_v[26:15] !== 12'h000) begin errors++; $display("FAIL b2b_frame2_low: got %03h required 000", ss_v[26:15]); end
        checks++; if (ss_v[39:27] !== 13'h1FFF) begin errors++; $display("FAIL b2b_after: got %04h required 1fff", ss_v[39:27]); end
        checks++; if (f1 !== 12'hEAD) begin errors++; $display("FAIL b2b_mosi1: got %03h required ead", f1); end
        checks++; if (f2 !== 12'h0FF) begin errors++; $display("FAIL b2b_mosi2: got %03h required 0ff", f2); end
        checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL b2b_rd_data_hold: got %02h required a5", bus.rd_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_din   = '0;
        slave_byte    = 8'h00;
        test_reset();
        test_reset_mid_frame();
        test_write_addr();
        test_write_data();
        test_ignore_busy();
        test_read_data();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
